// File: rtl/axis_multi_inject_shim_pkg.sv
// Shared types and width helpers for the AXIS multi-channel injection shim.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package axis_inject_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int flit_width(input int tdata_w, input int sf);
    return tdata_w / sf;
  endfunction

  function automatic int dest_width(input int tid_w, input int tdest_w);
    return tid_w + tdest_w;
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_multi_inject_shim_if.sv
// Bundle of per-channel AXI-Stream injection inputs.
// Latency: n/a (wiring only).
// Backpressure: tready per channel, driven by the shim.
interface axis_multi_inject_shim_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int TDATA_WIDTH  = 128,
  parameter int TID_WIDTH    = 2,
  parameter int TDEST_WIDTH  = 4
);
  logic [NUM_CHANNELS-1:0]                  tvalid;
  logic [NUM_CHANNELS-1:0]                  tready;
  logic [NUM_CHANNELS-1:0]                  tlast;
  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0] tdata;
  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]   tid;
  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_multi_inject_shim_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, with wrap.
// Latency: combinational.
// Backpressure: none; grant is one-hot or zero when no request.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic          found;
  logic [PW-1:0] cand;

  // Walk channels upward from the pointer and grant the first requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axis_multi_inject_shim.sv
// Arbitrates AXIS channels per packet and serializes each beat into credit-gated flits.
// Latency: beat accepted in cycle N, first flit offered in cycle N+1 when a credit is held.
// Backpressure: tready only while the beat register frees up; flits stall at zero credits.
module axis_multi_inject_shim
  import axis_inject_pkg::*;
#(
  parameter int NUM_CHANNELS         = 4,
  parameter int TDATA_WIDTH          = 128,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int SERIALIZATION_FACTOR = 2,
  parameter int FLIT_BUFFER_DEPTH    = 8,
  localparam int FLIT_WIDTH = flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR),
  localparam int DEST_WIDTH = dest_width(TID_WIDTH, TDEST_WIDTH)
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  axis_multi_inject_shim_if.slave axis_in,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in
);
  localparam int CW = credit_width(FLIT_BUFFER_DEPTH);
  localparam int IW = idx_width(SERIALIZATION_FACTOR);
  localparam int PW = idx_width(NUM_CHANNELS);

  state_e                  state_q, state_d;
  logic                    lock_q, lock_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           gnt_q, gnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           credit_q, credit_d;
  logic [TDATA_WIDTH-1:0]  beat_q, beat_d;
  logic [TID_WIDTH-1:0]    tid_q, tid_d;
  logic [TDEST_WIDTH-1:0]  tdest_q, tdest_d;
  logic                    tlast_q, tlast_d;

  logic [NUM_CHANNELS-1:0] arb_gnt;
  logic [PW-1:0]           arb_idx;
  logic [NUM_CHANNELS-1:0] tready_c;
  logic                    send, last_flit, load;
  logic [PW-1:0]           load_sel;

  rr_arbiter #(.N(NUM_CHANNELS), .PW(PW)) u_arb (
    .req   (axis_in.tvalid),
    .ptr   (ptr_q),
    .grant (arb_gnt)
  );

  // One-hot grant to channel index.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (arb_gnt[i]) arb_idx = PW'(i);
    end
  end

  // Flit offer depends only on registered state so it never loops back through tvalid.
  assign send      = (state_q == SEND) && (credit_q != '0);
  assign last_flit = (idx_q == IW'(SERIALIZATION_FACTOR - 1));

  assign send_out    = send;
  assign is_tail_out = send && last_flit && tlast_q;
  assign data_out    = beat_q[int'(idx_q)*FLIT_WIDTH +: FLIT_WIDTH];
  assign dest_out    = {tid_q, tdest_q};
  // Reset also masks tready so no beat appears accepted while flops are held clear.
  assign axis_in.tready = tready_c & {NUM_CHANNELS{rst_n}};

  // Packet-locked beat sequencing: arbitration in IDLE, serialization in SEND.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    beat_d   = beat_q;
    tid_d    = tid_q;
    tdest_d  = tdest_q;
    tlast_d  = tlast_q;
    tready_c = '0;
    load     = 1'b0;
    load_sel = gnt_q;
    case (state_q)
      IDLE: begin
        if (!lock_q) begin
          if (|axis_in.tvalid) begin
            tready_c = arb_gnt;
            load     = 1'b1;
            load_sel = arb_idx;
            gnt_d    = arb_idx;
            lock_d   = 1'b1;
            state_d  = SEND;
          end
        end else if (axis_in.tvalid[gnt_q]) begin
          tready_c[gnt_q] = 1'b1;
          load            = 1'b1;
          state_d         = SEND;
        end
      end
      SEND: begin
        if (send) begin
          if (!last_flit) begin
            idx_d = idx_q + 1'b1;
          end else if (tlast_q) begin
            // Packet complete: release the lock and move priority past this channel.
            lock_d  = 1'b0;
            ptr_d   = (gnt_q == PW'(NUM_CHANNELS - 1)) ? '0 : gnt_q + 1'b1;
            state_d = IDLE;
          end else begin
            // Mid-packet: refill the beat register in the same cycle for zero bubble.
            tready_c[gnt_q] = 1'b1;
            if (axis_in.tvalid[gnt_q]) load = 1'b1;
            else                       state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      beat_d  = axis_in.tdata[load_sel];
      tid_d   = axis_in.tid[load_sel];
      tdest_d = axis_in.tdest[load_sel];
      tlast_d = axis_in.tlast[load_sel];
      idx_d   = '0;
    end
  end

  // Credit counter: spend on each flit, refill on return, saturate at buffer depth.
  always_comb begin
    credit_d = credit_q;
    case ({send, credit_in})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   if (credit_q != CW'(FLIT_BUFFER_DEPTH)) credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lock_q   <= 1'b0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      idx_q    <= '0;
      credit_q <= CW'(FLIT_BUFFER_DEPTH);
      beat_q   <= '0;
      tid_q    <= '0;
      tdest_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
      beat_q   <= beat_d;
      tid_q    <= tid_d;
      tdest_q  <= tdest_d;
      tlast_q  <= tlast_d;
    end
  end
endmodule

// File: tb/tb_axis_multi_inject_shim.sv
// Directed bench for the injection shim: SF=2 instance for most scenarios, SF=1 instance for streaming.
// Inputs change at the falling edge; outputs are sampled 1ns later, before the next rising edge.
// Each scenario task checks its own outputs inline.
module tb_axis_multi_inject_shim;
  logic clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  logic rst_n = 1'b0;
  logic credit_in = 1'b0;
  logic credit1 = 1'b0;

  axis_multi_inject_shim_if #(.NUM_CHANNELS(4), .TDATA_WIDTH(128), .TID_WIDTH(2), .TDEST_WIDTH(4)) axis_if ();
  axis_multi_inject_shim_if #(.NUM_CHANNELS(4), .TDATA_WIDTH(32), .TID_WIDTH(2), .TDEST_WIDTH(4)) axis_if1 ();

  logic [63:0] data_out;
  logic [5:0]  dest_out;
  logic        is_tail_out, send_out;
  logic [31:0] data1;
  logic [5:0]  dest1;
  logic        tail1, send1;

  axis_multi_inject_shim #(
    .NUM_CHANNELS(4), .TDATA_WIDTH(128), .TID_WIDTH(2), .TDEST_WIDTH(4),
    .SERIALIZATION_FACTOR(2), .FLIT_BUFFER_DEPTH(8)
  ) dut (
    .clk_noc(clk_noc), .rst_n(rst_n), .axis_in(axis_if),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in)
  );

  axis_multi_inject_shim #(
    .NUM_CHANNELS(4), .TDATA_WIDTH(32), .TID_WIDTH(2), .TDEST_WIDTH(4),
    .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(8)
  ) dut1 (
    .clk_noc(clk_noc), .rst_n(rst_n), .axis_in(axis_if1),
    .data_out(data1), .dest_out(dest1), .is_tail_out(tail1),
    .send_out(send1), .credit_in(credit1)
  );

  int errors = 0;
  int checks = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    axis_if.tvalid = '0;  axis_if.tlast = '0;  axis_if.tdata = '0;
    axis_if.tid = '0;     axis_if.tdest = '0;
    axis_if1.tvalid = '0; axis_if1.tlast = '0; axis_if1.tdata = '0;
    axis_if1.tid = '0;    axis_if1.tdest = '0;
  endtask

  // Channel c, beat b: low flit = c*16+b*4, high flit = c*16+b*4+1; tid=c, tdest=c+4.
  task automatic drive_ch(input int c, input logic v, input int b, input logic last);
    axis_if.tvalid[c] = v;
    axis_if.tdata[c]  = {64'(c*16 + b*4 + 1), 64'(c*16 + b*4)};
    axis_if.tlast[c]  = last;
    axis_if.tid[c]    = 2'(c);
    axis_if.tdest[c]  = 4'(c + 4);
  endtask

  task automatic do_reset();
    @(negedge clk_noc);
    rst_n = 1'b0;
    clear_inputs();
    credit_in = 1'b0;
    credit1 = 1'b0;
    repeat (2) @(negedge clk_noc);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_noc);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_noc);
    axis_if.tvalid = 4'b1111;
    axis_if.tdata[0] = {64'h1, 64'h2};
    #1;
    checks++; if (axis_if.tready !== 4'b0000) begin errors++; $display("FAIL reset_tready got=%b exp=0000", axis_if.tready); end
    checks++; if (send_out !== 1'b0) begin errors++; $display("FAIL reset_send got=%b exp=0", send_out); end
    checks++; if (is_tail_out !== 1'b0) begin errors++; $display("FAIL reset_tail got=%b exp=0", is_tail_out); end
    checks++; if (data_out !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_out); end
    checks++; if (dest_out !== 6'h0) begin errors++; $display("FAIL reset_dest got=%h exp=0", dest_out); end
    checks++; if (send1 !== 1'b0) begin errors++; $display("FAIL reset_send_sf1 got=%b exp=0", send1); end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    do_reset();
    @(negedge clk_noc);
    axis_if.tvalid[2] = 1'b1;
    axis_if.tdata[2]  = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    axis_if.tlast[2]  = 1'b1;
    axis_if.tid[2]    = 2'b10;
    axis_if.tdest[2]  = 4'h9;
    #1;
    checks++; if (axis_if.tready !== 4'b0100) begin errors++; $display("FAIL sb_accept_tready got=%b exp=0100", axis_if.tready); end
    checks++; if (send_out !== 1'b0) begin errors++; $display("FAIL sb_accept_send got=%b exp=0", send_out); end
    @(negedge clk_noc);
    axis_if.tvalid[2] = 1'b0;
    #1;
    checks++; if (send_out !== 1'b1) begin errors++; $display("FAIL sb_f0_send got=%b exp=1", send_out); end
    checks++; if (data_out !== 64'h5555_5555_5555_5555) begin errors++; $display("FAIL sb_f0_data got=%h exp=5555555555555555", data_out); end
    checks++; if (dest_out !== 6'h29) begin errors++; $display("FAIL sb_f0_dest got=%h exp=29", dest_out); end
    checks++; if (is_tail_out !== 1'b0) begin errors++; $display("FAIL sb_f0_tail got=%b exp=0", is_tail_out); end
    checks++; if (axis_if.tready !== 4'b0000) begin errors++; $display("FAIL sb_f0_tready got=%b exp=0000", axis_if.tready); end
    @(negedge clk_noc); #1;
    checks++; if (send_out !== 1'b1) begin errors++; $display("FAIL sb_f1_send got=%b exp=1", send_out); end
    checks++; if (data_out !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL sb_f1_data got=%h exp=aaaaaaaaaaaaaaaa", data_out); end
    checks++; if (dest_out !== 6'h29) begin errors++; $display("FAIL sb_f1_dest got=%h exp=29", dest_out); end
    checks++; if (is_tail_out !== 1'b1) begin errors++; $display("FAIL sb_f1_tail got=%b exp=1", is_tail_out); end
    @(negedge clk_noc); #1;
    checks++; if (send_out !== 1'b0) begin errors++; $display("FAIL sb_after_send got=%b exp=0", send_out); end
  endtask

  task automatic test_lock();
    do_reset();
    credit_in = 1'b1;
    @(negedge clk_noc);
    drive_ch(0, 1'b1, 0, 1'b0);
    #1;
    checks++; if (axis_if.tready !== 4'b0001) begin errors++; $display("FAIL lock_first_tready got=%b exp=0001", axis_if.tready); end
    @(negedge clk_noc);
    drive_ch(0, 1'b0, 0, 1'b0);
    drive_ch(3, 1'b1, 0, 1'b1);
    #1;
    checks++; if (axis_if.tready !== 4'b0000) begin errors++; $display("FAIL lock_f0_tready got=%b exp=0000", axis_if.tready); end
    @(negedge clk_noc); #1;
    checks++; if (axis_if.tready !== 4'b0001) begin errors++; $display("FAIL lock_done_tready got=%b exp=0001", axis_if.tready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_noc); #1;
      checks++; if (axis_if.tready !== 4'b0000 || send_out !== 1'b0) begin errors++; $display("FAIL lock_hold cyc=%0d tready=%b send=%b exp tready=0000 send=0", i, axis_if.tready, send_out); end
    end
    @(negedge clk_noc);
    drive_ch(0, 1'b1, 1, 1'b1);
    #1;
    checks++; if (axis_if.tready !== 4'b0001) begin errors++; $display("FAIL lock_resume_tready got=%b exp=0001", axis_if.tready); end
    @(negedge clk_noc);
    drive_ch(0, 1'b0, 1, 1'b0);
    #1;
    checks++; if (send_out !== 1'b1 || data_out !== 64'd4) begin errors++; $display("FAIL lock_resume_flit send=%b data=%h exp send=1 data=4", send_out, data_out); end
  endtask

  task automatic test_round_robin();
    int bc[4];
    logic [63:0] got_d[$];
    logic got_t[$];
    int order[4];
    int ch, b, j, expv;
    order = '{0, 1, 3, 0};
    bc = '{0, 0, 0, 0};
    do_reset();
    credit_in = 1'b1;
    for (int cyc = 0; cyc < 200 && got_d.size() < 16; cyc++) begin
      @(negedge clk_noc);
      drive_ch(0, 1'b1, bc[0], (bc[0] % 2) == 1);
      drive_ch(1, 1'b1, bc[1], (bc[1] % 2) == 1);
      drive_ch(3, 1'b1, bc[3], (bc[3] % 2) == 1);
      #1;
      if (send_out) begin got_d.push_back(data_out); got_t.push_back(is_tail_out); end
      for (int c = 0; c < 4; c++) if (axis_if.tready[c]) bc[c]++;
    end
    checks++; if (got_d.size() != 16) begin errors++; $display("FAIL rr_flit_count got=%0d exp=16", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 16; i++) begin
      j = i % 4;
      ch = order[i / 4];
      b = (i / 4 == 3) ? 2 + j / 2 : j / 2;
      expv = ch * 16 + b * 4 + (j % 2);
      checks++; if (got_d[i] !== 64'(expv)) begin errors++; $display("FAIL rr_flit_data idx=%0d got=%h exp=%h", i, got_d[i], expv); end
      checks++; if (got_t[i] !== (j == 3)) begin errors++; $display("FAIL rr_flit_tail idx=%0d got=%b exp=%b", i, got_t[i], (j == 3)); end
    end
  endtask

  task automatic test_credit_stall();
    int cnt;
    do_reset();
    @(negedge clk_noc);
    credit_in = 1'b1;
    repeat (3) @(negedge clk_noc);
    credit_in = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_noc);
      drive_ch(0, 1'b1, 0, 1'b0);
      #1;
      if (send_out) cnt++;
    end
    checks++; if (cnt != 8) begin errors++; $display("FAIL credit_initial_sends got=%0d exp=8", cnt); end
    checks++; if (send_out !== 1'b0) begin errors++; $display("FAIL credit_stalled got=%b exp=0", send_out); end
    @(negedge clk_noc);
    credit_in = 1'b1;
    #1;
    cnt = send_out ? 1 : 0;
    @(negedge clk_noc);
    credit_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (send_out) cnt++;
      @(negedge clk_noc);
    end
    checks++; if (cnt != 1) begin errors++; $display("FAIL credit_one_more got=%0d exp=1", cnt); end
  endtask

  task automatic test_credit_balance();
    int cnt;
    do_reset();
    credit_in = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_noc);
      drive_ch(1, 1'b1, 0, 1'b0);
      #1;
      if (send_out) cnt++;
    end
    checks++; if (cnt != 19) begin errors++; $display("FAIL balance_sends got=%0d exp=19", cnt); end
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_noc);
      credit_in = 1'b0;
      #1;
      if (send_out) cnt++;
    end
    checks++; if (cnt != 8) begin errors++; $display("FAIL balance_remaining got=%0d exp=8", cnt); end
  endtask

  task automatic test_reset_mid_packet();
    int cnt;
    do_reset();
    @(negedge clk_noc);
    drive_ch(2, 1'b1, 0, 1'b1);
    @(negedge clk_noc);
    drive_ch(2, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk_noc);
    drive_ch(1, 1'b1, 0, 1'b0);
    #1;
    checks++; if (axis_if.tready !== 4'b0010) begin errors++; $display("FAIL rmp_accept_tready got=%b exp=0010", axis_if.tready); end
    @(negedge clk_noc);
    drive_ch(1, 1'b1, 1, 1'b0);
    #1;
    checks++; if (send_out !== 1'b1 || data_out !== 64'd16) begin errors++; $display("FAIL rmp_first_flit send=%b data=%h exp send=1 data=10", send_out, data_out); end
    @(negedge clk_noc);
    rst_n = 1'b0;
    #1;
    checks++; if (send_out !== 1'b0 || is_tail_out !== 1'b0) begin errors++; $display("FAIL rmp_rst_ctrl send=%b tail=%b exp 0 0", send_out, is_tail_out); end
    checks++; if (data_out !== 64'h0 || dest_out !== 6'h0) begin errors++; $display("FAIL rmp_rst_bus data=%h dest=%h exp 0 0", data_out, dest_out); end
    checks++; if (axis_if.tready !== 4'b0000) begin errors++; $display("FAIL rmp_rst_tready got=%b exp=0000", axis_if.tready); end
    @(negedge clk_noc);
    rst_n = 1'b1;
    clear_inputs();
    @(negedge clk_noc);
    drive_ch(1, 1'b1, 0, 1'b0);
    drive_ch(3, 1'b1, 0, 1'b0);
    #1;
    checks++; if (axis_if.tready !== 4'b0010) begin errors++; $display("FAIL rmp_ptr_tready got=%b exp=0010", axis_if.tready); end
    @(negedge clk_noc);
    #1;
    checks++; if (send_out !== 1'b1 || data_out !== 64'd16) begin errors++; $display("FAIL rmp_restart_flit send=%b data=%h exp send=1 data=10", send_out, data_out); end
    cnt = send_out ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_noc);
      #1;
      if (send_out) cnt++;
    end
    checks++; if (cnt != 8) begin errors++; $display("FAIL rmp_credits got=%0d exp=8", cnt); end
  endtask

  task automatic test_sf1_stream();
    int b;
    int expb;
    logic exp_send;
    do_reset();
    credit1 = 1'b1;
    b = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk_noc);
      axis_if1.tvalid[0] = 1'b1;
      axis_if1.tdata[0]  = 32'(b);
      axis_if1.tlast[0]  = (b % 3) == 2;
      axis_if1.tid[0]    = 2'd0;
      axis_if1.tdest[0]  = 4'd4;
      #1;
      exp_send = (cyc % 4) != 0;
      expb = (cyc / 4) * 3 + (cyc % 4) - 1;
      checks++; if (send1 !== exp_send) begin errors++; $display("FAIL sf1_send cyc=%0d got=%b exp=%b", cyc, send1, exp_send); end
      if (exp_send) begin
        checks++; if (data1 !== 32'(expb) || dest1 !== 6'h04) begin errors++; $display("FAIL sf1_flit cyc=%0d data=%h dest=%h exp data=%h dest=04", cyc, data1, dest1, expb); end
        checks++; if (tail1 !== ((cyc % 4) == 3)) begin errors++; $display("FAIL sf1_tail cyc=%0d got=%b exp=%b", cyc, tail1, (cyc % 4) == 3); end
      end
      if (axis_if1.tready[0]) b++;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_beat();
    test_lock();
    test_round_robin();
    test_credit_stall();
    test_credit_balance();
    test_reset_mid_packet();
    test_sf1_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_multi_inject_shim.md
AXIS_MULTI_INJECT_SHIM -- requirements
Module: axis_multi_inject_shim

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of AXI-Stream injection channels (1..8).
REQ-002 Parameter TDATA_WIDTH, default 128: AXIS beat width.
REQ-003 Parameter TID_WIDTH, default 2; TDEST_WIDTH, default 4: AXIS tid/tdest widths.
REQ-004 Parameter SERIALIZATION_FACTOR, default 2: flits per beat (1, 2, 4 or 8; must divide TDATA_WIDTH).
REQ-005 Parameter FLIT_BUFFER_DEPTH, default 8: downstream router input buffer depth, the initial credit count.
REQ-006 Derived: FLIT_WIDTH = TDATA_WIDTH/SERIALIZATION_FACTOR; DEST_WIDTH = TDEST_WIDTH+TID_WIDTH.
REQ-007 clk_noc  input  1  single clock, all logic rising-edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 axis_in_tvalid  input  [NUM_CHANNELS]  per-channel beat valid.
REQ-010 axis_in_tready  output  [NUM_CHANNELS]  per-channel beat accept.
REQ-011 axis_in_tdata  input  [NUM_CHANNELS][TDATA_WIDTH]  beat payload.
REQ-012 axis_in_tlast / axis_in_tid / axis_in_tdest  input  [NUM_CHANNELS] x 1 / TID_WIDTH / TDEST_WIDTH  end of packet, id, destination.
REQ-013 data_out  output  FLIT_WIDTH  flit to router local input.
REQ-014 dest_out  output  DEST_WIDTH  {tid, tdest} of current beat.
REQ-015 is_tail_out / send_out  output  1 / 1  tail flag; flit valid.
REQ-016 credit_in  input  1  one-flit credit return from router.

Function
REQ-017 States IDLE and SEND. IDLE: beat register empty. SEND: beat register holds one beat; flit index idx (0..SERIALIZATION_FACTOR-1).
REQ-018 In IDLE with no lock held and any tvalid set, the round-robin arbiter picks grant g, tready[g]=1 for that cycle only; beat, tid, tdest, tlast captured, idx=0, lock set, next state SEND.
REQ-019 In IDLE with lock held, only tready[g] may assert (when tvalid[g]=1); all other tready stay 0.
REQ-020 In SEND, send_out = (credit_count > 0); combinational from registers only, never from axis_in_* inputs.
REQ-021 data_out = beat[idx*FLIT_WIDTH +: FLIT_WIDTH] (LSB slice first); dest_out constant for all flits of a beat.
REQ-022 is_tail_out = send_out && idx == SERIALIZATION_FACTOR-1 && stored tlast.
REQ-023 On send_out with idx < SF-1: idx increments. On send_out with idx == SF-1: beat done.
REQ-024 On beat done with lock held and stored tlast=0: tready[g] asserted same cycle; if tvalid[g]=1, next beat loaded, stay SEND (zero-bubble); else go IDLE.
REQ-025 On beat done with stored tlast=1: lock cleared, RR pointer = g+1 mod NUM_CHANNELS, go IDLE; no new beat loaded this cycle.
REQ-026 Round-robin: first asserted tvalid searching upward from pointer with wrap; pointer changes only at tail.
REQ-027 Latency: beat accepted cycle N -> first flit send_out cycle N+1 if credit available.
REQ-028 credit_count width clog2(FLIT_BUFFER_DEPTH+1); -1 on send_out, +1 on credit_in, unchanged when both; never exceeds FLIT_BUFFER_DEPTH nor underflows.
REQ-029 credit_count = 0: send_out=0, idx and beat held until credit_in.
REQ-030 SERIALIZATION_FACTOR=1: each beat is one flit; REQ-023 reduces to beat done every send.

Reset
REQ-031 rst_n low asynchronously clears: state=IDLE, lock=0, RR pointer=0, idx=0, credit_count=FLIT_BUFFER_DEPTH, beat/tid/tdest/tlast registers=0.
REQ-032 During and after reset: tready all 0, send_out=0, is_tail_out=0, data_out=0, dest_out=0.
REQ-033 Reset mid-packet discards the partial packet; no flit is resent after release.

Structure
REQ-034 Package axis_inject_pkg holds the state enum (IDLE, SEND) and width helper functions for FLIT_WIDTH, DEST_WIDTH and credit width.
REQ-035 One sub-module rr_arbiter (NUM_CHANNELS requests, pointer input, one-hot grant out); all other logic inline.

Verification
REQ-036 NUM_CHANNELS=4, SF=2: ch2 sends one beat tdata=0xAAAA..._5555..., tlast=1 -> two flits 0x5555..., then 0xAAAA... with is_tail_out on flit 2, dest_out={tid,tdest} both.
REQ-037 Channels 0,1,3 valid continuously with 2-beat packets -> packet order 0,1,3,0; no interleaving of flits from different channels.
REQ-038 FLIT_BUFFER_DEPTH=8, credit_in held 0 -> exactly 8 send_out pulses then stall; one credit_in pulse -> exactly one more flit.
REQ-039 Simultaneous send_out and credit_in for 20 cycles -> credit_count constant; assertion count never > 8.
REQ-040 rst_n low after first flit of a 3-beat packet -> all outputs 0 immediately, credit_count=8 after release, next accepted packet starts at flit 0 from RR pointer 0.
REQ-041 SF=1, single channel, tvalid continuous, ample credit -> one send_out per cycle within a packet, one idle cycle after each tail.
